// File: rtl/m_data_mem_responder.sv
// CPU data-port responder: word RAM, console TX FIFO and cycle counter on an I/O page.
// Reads are combinational with no side effects; writes land at posedge; the TX byte stream drains on valid/ready.
module m_data_mem_responder #(
  parameter int          MEM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_WE,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data_to_mem,
  output logic [31:0] o_data_from_mem,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_bus_err
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0]   r_mem  [MEM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_bus_err;
  logic [31:0]   r_cycle;

  logic        w_aligned, w_ram_hit, w_io_hit;
  logic        w_ram_sel, w_tx_sel, w_stat_sel, w_cyc_sel;
  logic        w_bad, w_err_set;
  logic        w_full, w_empty, w_pop, w_push, w_drop;
  logic [31:0] w_status;

  assign w_aligned  = (i_address[1:0] == 2'b00);
  assign w_ram_hit  = (i_address < RAM_BYTES);
  assign w_io_hit   = (i_address[31:8] == IO_BASE[31:8]);
  assign w_ram_sel  = w_ram_hit && w_aligned;
  assign w_tx_sel   = w_io_hit && (i_address[7:0] == 8'h00);
  assign w_stat_sel = w_io_hit && (i_address[7:0] == 8'h04);
  assign w_cyc_sel  = w_io_hit && (i_address[7:0] == 8'h08);
  assign w_bad      = !(w_ram_sel || w_tx_sel || w_stat_sel || w_cyc_sel);
  // The ALU output is decoded every cycle, so a plain unmapped read is not an error.
  assign w_err_set  = w_bad && (i_WE || (!w_aligned && (w_ram_hit || w_io_hit)));

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && i_tx_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push   = i_WE && w_tx_sel && (!w_full || w_pop);
  assign w_drop   = i_WE && w_tx_sel && w_full && !w_pop;
  assign w_status = {16'b0, 8'(r_count), 5'b0, r_ovf, w_empty, w_full};

  always_comb begin
    o_data_from_mem = 32'h0;
    if (w_ram_sel)       o_data_from_mem = r_mem[i_address[AW+1:2]];
    else if (w_stat_sel) o_data_from_mem = w_status;
    else if (w_cyc_sel)  o_data_from_mem = r_cycle;
  end

  assign o_tx_valid = !w_empty;
  assign o_tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign o_bus_err  = r_bus_err;

  always_ff @(posedge i_clk) begin
    if (i_WE && w_ram_sel) r_mem[i_address[AW+1:2]] <= i_data_to_mem;
    if (w_push)            r_fifo[r_wr_ptr] <= i_data_to_mem[7:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_bus_err <= 1'b0;
      r_cycle   <= 32'h0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      if (w_drop)                                           r_ovf <= 1'b1;
      else if (i_WE && w_stat_sel && i_data_to_mem[2])      r_ovf <= 1'b0;

      if (w_err_set) r_bus_err <= 1'b1;

      if (i_WE && w_cyc_sel) r_cycle <= i_data_to_mem;
      else                   r_cycle <= r_cycle + 32'd1;
    end
  end

endmodule

// File: tb/tb_m_data_mem_responder.sv
// Directed test-plan sequences followed by random traffic, all checked against a queue/array model of the address map.
module tb_m_data_mem_responder;

  localparam logic [31:0] IO = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_WE;
  logic [31:0] i_address;
  logic [31:0] i_data_to_mem;
  logic [31:0] o_data_from_mem;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        o_bus_err;

  m_data_mem_responder dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_WE           (i_WE),
    .i_address      (i_address),
    .i_data_to_mem  (i_data_to_mem),
    .o_data_from_mem(o_data_from_mem),
    .o_tx_valid     (o_tx_valid),
    .o_tx_data      (o_tx_data),
    .i_tx_ready     (i_tx_ready),
    .o_bus_err      (o_bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_ram [256];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic        m_err;
  logic [31:0] m_cyc;

  logic [31:0] rd;
  logic [7:0]  txd;
  logic [31:0] old;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'b0, 8'(m_q.size()), 5'b0, m_ovf, m_q.size() == 0, m_q.size() == 8};
  endfunction

  function automatic bit m_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd1024 || a == IO || a == IO + 4 || a == IO + 8);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_ok(a))    return 32'h0;
    if (a < 32'd1024) return m_ram[a[9:2]];
    if (a == IO + 4) return m_status();
    if (a == IO + 8) return m_cyc;
    return 32'h0;
  endfunction

  // Drive one bus cycle from the low clock phase, check combinational outputs, then advance the model across the edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy,
                      output logic [31:0] rdata, output logic [7:0] tdata);
    int sz;
    bit pop;
    i_WE = we; i_address = a; i_data_to_mem = d; i_tx_ready = rdy;
    #1;
    rdata = o_data_from_mem;
    tdata = o_tx_data;
    chk_eq("rdata", rdata, m_read(a));
    chk_eq("tx_valid", 32'(o_tx_valid), 32'(m_q.size() != 0));
    chk_eq("tx_data", 32'(tdata), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk_eq("bus_err", 32'(o_bus_err), 32'(m_err));
    @(posedge clk);
    sz  = m_q.size();
    pop = (sz != 0) && rdy;
    if (!m_ok(a) && (we || (a[1:0] != 2'b00 && (a < 32'd1024 || a >= IO)))) m_err = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (we && m_ok(a) && a == IO) begin
      if (sz < 8 || pop) m_q.push_back(d[7:0]);
      else               m_ovf = 1'b1;
    end
    if (we && m_ok(a) && a == IO + 4 && d[2]) m_ovf = 1'b0;
    if (we && m_ok(a) && a == IO + 8) m_cyc = d;
    else                              m_cyc = m_cyc + 32'd1;
    if (we && m_ok(a) && a < 32'd1024) m_ram[a[9:2]] = d;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    i_reset_n = 1'b0; i_WE = 1'b0; i_address = '0; i_data_to_mem = '0; i_tx_ready = 1'b0;
    m_q.delete(); m_ovf = 1'b0; m_err = 1'b0; m_cyc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_eq("rst_tx_valid", 32'(o_tx_valid), 32'h0);
    chk_eq("rst_tx_data", 32'(o_tx_data), 32'h0);
    chk_eq("rst_bus_err", 32'(o_bus_err), 32'h0);
    i_reset_n = 1'b1;
    step(0, IO + 8, 0, 0, rd, txd); chk_eq("rst_cycle", rd, 32'h0);
    step(0, IO + 4, 0, 0, rd, txd); chk_eq("rst_status", rd, 32'h0000_0002);

    for (int i = 0; i < 256; i++) step(1, 32'(i) << 2, $urandom, 0, rd, txd);

    old = m_ram[4];
    step(1, 32'h10, 32'hDEAD_BEEF, 0, rd, txd); chk_eq("ram_old_in_wr_cycle", rd, old);
    step(0, 32'h10, 0, 0, rd, txd);             chk_eq("ram_rd_after_wr", rd, 32'hDEAD_BEEF);
    step(0, 32'h14, 0, 0, rd, txd);

    step(1, IO, 32'h48, 0, rd, txd);
    step(1, IO, 32'h69, 0, rd, txd);
    step(0, IO + 4, 0, 0, rd, txd); chk_eq("status_two", rd, 32'h0000_0200);
    step(0, 32'h10, 0, 1, rd, txd); chk_eq("tx_byte_H", 32'(txd), 32'h48);
    step(0, 32'h10, 0, 1, rd, txd); chk_eq("tx_byte_i", 32'(txd), 32'h69);
    step(0, IO + 4, 0, 0, rd, txd); chk_eq("status_drained", rd, 32'h0000_0002);

    for (int i = 0; i < 9; i++) step(1, IO, 32'h30 + 32'(i), 0, rd, txd);
    step(0, IO + 4, 0, 0, rd, txd);    chk_eq("status_ovf", rd, 32'h0000_0805);
    step(1, IO, 32'h55, 1, rd, txd);   chk_eq("full_pop_head", 32'(txd), 32'h30);
    step(0, IO + 4, 0, 0, rd, txd);    chk_eq("status_full_pushpop", rd, 32'h0000_0805);
    step(1, IO + 4, 32'h4, 0, rd, txd);
    step(0, IO + 4, 0, 0, rd, txd);    chk_eq("status_w1c", rd, 32'h0000_0801);
    repeat (8) step(0, 32'h0, 0, 1, rd, txd);
    step(0, IO + 4, 0, 0, rd, txd);    chk_eq("status_empty", rd, 32'h0000_0002);

    step(1, IO + 8, 32'hFFFF_FFFE, 0, rd, txd);
    step(0, IO + 8, 0, 0, rd, txd); chk_eq("cyc_load", rd, 32'hFFFF_FFFE);
    step(0, IO + 8, 0, 0, rd, txd); chk_eq("cyc_max", rd, 32'hFFFF_FFFF);
    step(0, IO + 8, 0, 0, rd, txd); chk_eq("cyc_wrap", rd, 32'h0);

    step(0, 32'h8000_0000, 0, 0, rd, txd); chk_eq("unmapped_rd_zero", rd, 32'h0);
    chk_eq("unmapped_rd_no_err", 32'(o_bus_err), 32'h0);
    step(1, 32'h12, 32'h1234_5678, 0, rd, txd);
    chk_eq("misaligned_wr_err", 32'(o_bus_err), 32'h1);
    step(0, 32'h10, 0, 0, rd, txd); chk_eq("misaligned_wr_ignored", rd, 32'hDEAD_BEEF);
    step(1, IO + 32'hC, 32'h5, 0, rd, txd);
    step(0, IO + 8, 0, 0, rd, txd);

    for (int i = 0; i < 5; i++) step(1, IO, 32'hA0 + 32'(i), 0, rd, txd);
    i_WE = 1'b0; i_address = 32'h0; i_tx_ready = 1'b1;
    #2 i_reset_n = 1'b0;
    #1;
    chk_eq("async_rst_tx_valid", 32'(o_tx_valid), 32'h0);
    chk_eq("async_rst_tx_data", 32'(o_tx_data), 32'h0);
    chk_eq("async_rst_bus_err", 32'(o_bus_err), 32'h0);
    @(posedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    m_q.delete(); m_ovf = 1'b0; m_err = 1'b0; m_cyc = 32'h0;
    step(0, IO + 8, 0, 0, rd, txd); chk_eq("post_rst_cycle", rd, 32'h0);
    step(0, IO + 4, 0, 0, rd, txd); chk_eq("post_rst_status", rd, 32'h0000_0002);
    step(0, 32'h10, 0, 0, rd, txd); chk_eq("post_rst_ram", rd, 32'hDEAD_BEEF);

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: a = 32'($urandom_range(0, 255)) << 2;
        3:       a = 32'($urandom_range(0, 1023));
        4, 5:    a = IO;
        6:       a = IO + 4;
        7:       a = IO + 8;
        8:       a = IO | 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 3) == 0), rd, txd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
